// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encoding and
// the elaboration-time parameter sanity check.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // WIDTH must split into a whole number of CHUNK-bit slices.
  function automatic bit params_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple slice; also exposes the carry into its MSB
// so the top slice can form the signed-overflow flag.
module chunk_adder
  import addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic carry;

  always_comb begin
    carry = ci;
    cm    = ci;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cm    = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage, operands
// skewed forward and finished result chunks deskewed so SUM leaves aligned.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // The whole pipe advances together; it only holds when the result is stuck.
  assign en       = !OUT_VALID || OUT_READY;
  assign IN_READY = en;
  assign b_eff    = (SUB == MODE_SUB) ? ~B : B;
  assign c0       = (SUB == MODE_SUB) ? ~CIN : CIN;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO   = gi * CHUNK;
    localparam int PEND = WIDTH - LO;

    logic [PEND-1:0]     a_src;
    logic [PEND-1:0]     b_src;
    logic                c_src;
    logic                v_src;
    logic [CHUNK-1:0]    s_chunk;
    logic                co;
    logic                cm;
    logic [LO+CHUNK-1:0] s_next;
    logic                v_reg;
    logic                c_reg;
    logic [LO+CHUNK-1:0] s_reg;

    if (gi == 0) begin : g_head
      assign a_src  = A;
      assign b_src  = b_eff;
      assign c_src  = c0;
      assign v_src  = IN_VALID;
      assign s_next = s_chunk;
    end else begin : g_body
      assign a_src  = g_stage[gi-1].g_skew.a_skew_reg;
      assign b_src  = g_stage[gi-1].g_skew.b_skew_reg;
      assign c_src  = g_stage[gi-1].c_reg;
      assign v_src  = g_stage[gi-1].v_reg;
      assign s_next = {s_chunk, g_stage[gi-1].s_reg};
    end

    chunk_adder #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a (a_src[CHUNK-1:0]),
      .b (b_src[CHUNK-1:0]),
      .ci(c_src),
      .s (s_chunk),
      .co(co),
      .cm(cm)
    );

    always_ff @(posedge CLK) begin
      if (RST) begin
        v_reg <= 1'b0;
        c_reg <= 1'b0;
        s_reg <= '0;
      end else if (en) begin
        v_reg <= v_src;
        c_reg <= co;
        s_reg <= s_next;
      end
    end

    // Operand bits not yet consumed ride along to the next slice.
    if (gi < STAGES - 1) begin : g_skew
      logic [PEND-CHUNK-1:0] a_skew_reg;
      logic [PEND-CHUNK-1:0] b_skew_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          a_skew_reg <= '0;
          b_skew_reg <= '0;
        end else if (en) begin
          a_skew_reg <= a_src[PEND-1:CHUNK];
          b_skew_reg <= b_src[PEND-1:CHUNK];
        end
      end
    end

    if (gi == STAGES - 1) begin : g_tail
      logic ovf_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          ovf_reg <= 1'b0;
        end else if (en) begin
          ovf_reg <= co ^ cm;
        end
      end
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = cm;
    end
  end

  assign OUT_VALID = g_stage[STAGES-1].v_reg;
  assign SUM       = g_stage[STAGES-1].s_reg;
  assign COUT      = g_stage[STAGES-1].c_reg;
  assign OVF       = g_stage[STAGES-1].g_tail.ovf_reg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and randomised checks of pipelined_addsub at 16/4, 32/8 and 8/8.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf;
  logic [31:0] w_a, w_b, w_sum;

  logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_cout, n_ovf;
  logic [7:0]  n_a, n_b, n_sum;

  int checks = 0;
  int errors = 0;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .CIN(cin), .SUB(sub),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .SUM(sum), .COUT(cout), .OVF(ovf)
  );

  pipelined_addsub #(.WIDTH(32), .CHUNK(8)) u_dut_w (
    .CLK(clk), .RST(rst), .IN_VALID(w_in_valid), .IN_READY(w_in_ready),
    .A(w_a), .B(w_b), .CIN(w_cin), .SUB(w_sub),
    .OUT_VALID(w_out_valid), .OUT_READY(w_out_ready),
    .SUM(w_sum), .COUT(w_cout), .OVF(w_ovf)
  );

  pipelined_addsub #(.WIDTH(8), .CHUNK(8)) u_dut_n (
    .CLK(clk), .RST(rst), .IN_VALID(n_in_valid), .IN_READY(n_in_ready),
    .A(n_a), .B(n_b), .CIN(n_cin), .SUB(n_sub),
    .OUT_VALID(n_out_valid), .OUT_READY(n_out_ready),
    .SUM(n_sum), .COUT(n_cout), .OVF(n_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {cout, ovf, sum[31:0]} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic cin_i, input logic sub_i);
    logic [63:0] m, be, wide;
    logic        c0_i, ov;
    m    = (64'd1 << w) - 64'd1;
    be   = (sub_i ? ~{32'b0, b_i} : {32'b0, b_i}) & m;
    c0_i = sub_i ? ~cin_i : cin_i;
    wide = ({32'b0, a_i} & m) + be + {63'b0, c0_i};
    ov   = (a_i[w-1] == be[w-1]) && (wide[w-1] != a_i[w-1]);
    return {wide[w], ov, wide[31:0] & m[31:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts,
                          input logic [15:0] es, input logic ec, input logic eo);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    check({tag, " early"}, {63'b0, out_valid}, 64'd0);
    cyc();
    check({tag, " valid"}, {63'b0, out_valid}, 64'd1);
    check({tag, " sum"}, {48'b0, sum}, {48'b0, es});
    check({tag, " cout"}, {63'b0, cout}, {63'b0, ec});
    check({tag, " ovf"}, {63'b0, ovf}, {63'b0, eo});
    $display("beat %s A=%h B=%h CIN=%b SUB=%b -> SUM=%h COUT=%b OVF=%b", tag, ta, tb, tc, ts, sum, cout, ovf);
    cyc();
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL timeout simulation did not finish");
  end

  initial begin
    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic [33:0] e;
    logic [33:0] qw [$];
    logic [33:0] qn [$];
    logic [63:0] exp;
    logic        held, ghost;
    logic [15:0] held_sum;
    int          tx, rx;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; sub = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_a = '0; n_b = '0; n_cin = 1'b0; n_sub = 1'b0;

    // Reset, with a beat offered that must be discarded.
    cyc();
    check("reset in_ready", {63'b0, in_ready}, 64'd1);
    cyc();
    check("reset out_valid", {63'b0, out_valid}, 64'd0);
    check("reset sum", {48'b0, sum}, 64'd0);
    check("reset cout", {63'b0, cout}, 64'd0);
    check("reset ovf", {63'b0, ovf}, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    ghost = 1'b0;
    repeat (6) begin
      if (out_valid) ghost = 1'b1;
      cyc();
    end
    check("reset beat discarded", {63'b0, ghost}, 64'd0);

    run_beat("add basic",  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_beat("add wrap",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_beat("add ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_beat("add cin",    16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    run_beat("sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_beat("sub ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_beat("sub bin",    16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

    // Back-to-back stream with the consumer stalling in cycles 5..8.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'(16'h2000 * i + 16'h00F0 + i);
      sb[i] = 16'h1357 ^ 16'(16'h0101 * i);
    end
    tx = 0; rx = 0; held = 1'b0; held_sum = '0;
    for (int c = 1; c <= 40 && rx < 8; c++) begin
      out_ready = !(c >= 5 && c <= 8);
      in_valid  = (tx < 8);
      if (tx < 8) begin
        a = sa[tx]; b = sb[tx]; sub = tx[0]; cin = tx[1];
      end
      #1;
      if (out_valid && !out_ready) check("stall in_ready", {63'b0, in_ready}, 64'd0);
      if (held) check("stall frozen", {47'b0, out_valid, sum}, {47'b0, 1'b1, held_sum});
      held = out_valid && !out_ready;
      held_sum = sum;
      if (out_valid && out_ready) begin
        e = model(16, {16'b0, sa[rx]}, {16'b0, sb[rx]}, rx[1], rx[0]);
        check("stream result", {30'b0, cout, ovf, 16'b0, sum}, {30'b0, e});
        $display("stream beat %0d SUM=%h COUT=%b OVF=%b", rx, sum, cout, ovf);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream delivered", 64'(rx), 64'd8);
    ghost = 1'b0;
    repeat (5) begin
      if (out_valid) ghost = 1'b1;
      cyc();
    end
    check("stream no duplicate", {63'b0, ghost}, 64'd0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      a = 16'(16'h0100 * (i + 1)); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      cyc();
    end
    rst = 1'b1; a = 16'hAAAA; b = 16'h1111;
    cyc();
    check("midrst out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst sum", {48'b0, sum}, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    ghost = 1'b0;
    repeat (6) begin
      if (out_valid) ghost = 1'b1;
      cyc();
    end
    check("midrst dropped", {63'b0, ghost}, 64'd0);
    run_beat("post reset", 16'h4321, 16'h1234, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Random regression with backpressure on the 32/8 and 8/8 instances.
    for (int c = 0; c < 440; c++) begin
      if (c < 400) begin
        w_in_valid = ($urandom_range(0, 3) != 0);
        n_in_valid = ($urandom_range(0, 3) != 0);
        w_out_ready = ($urandom_range(0, 3) != 0);
        n_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        w_in_valid = 1'b0; n_in_valid = 1'b0; w_out_ready = 1'b1; n_out_ready = 1'b1;
      end
      w_a = $urandom; w_b = $urandom; w_cin = 1'($urandom_range(0, 1)); w_sub = 1'($urandom_range(0, 1));
      n_a = 8'($urandom); n_b = 8'($urandom); n_cin = 1'($urandom_range(0, 1)); n_sub = 1'($urandom_range(0, 1));
      #1;
      if (w_in_valid && w_in_ready) qw.push_back(model(32, w_a, w_b, w_cin, w_sub));
      if (n_in_valid && n_in_ready) qn.push_back(model(8, {24'b0, n_a}, {24'b0, n_b}, n_cin, n_sub));
      if (w_out_valid && w_out_ready) begin
        exp = '1;
        if (qw.size() != 0) exp = {30'b0, qw.pop_front()};
        check("w32 beat", {30'b0, w_cout, w_ovf, w_sum}, exp);
      end
      if (n_out_valid && n_out_ready) begin
        exp = '1;
        if (qn.size() != 0) exp = {30'b0, qn.pop_front()};
        check("n8 beat", {30'b0, n_cout, n_ovf, 24'b0, n_sum}, exp);
      end
      cyc();
    end
    check("w32 drained", 64'(qw.size()), 64'd0);
    check("n8 drained", 64'(qn.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
